// File: rtl/ps2_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_frame_rx_if
// Purpose  : PS/2 line inputs and decoded key-event outputs of ps2_frame_rx.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_frame_rx_if;
  logic       kclk;
  logic       kdata;
  logic [7:0] key_code;
  logic       key_release;
  logic       key_extended;
  logic       key_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  // master drives the PS/2 lines and consumes key events
  modport master (
    output kclk, kdata,
    input  key_code, key_release, key_extended, key_valid,
    input  parity_err, frame_err, rx_busy
  );

  // slave is the receiver
  modport slave (
    input  kclk, kdata,
    output key_code, key_release, key_extended, key_valid,
    output parity_err, frame_err, rx_busy
  );
endinterface
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_frame_rx
// Purpose  : PS/2 device-to-host frame receiver with set-2 E0/F0 prefix
//            decoding, parity/framing/timeout error strobes.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TO_W           = 18
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  ps2_frame_rx_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  localparam logic [TO_W-1:0] C_TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      C_EXT_CODE = 8'hE0;
  localparam logic [7:0]      C_BRK_CODE = 8'hF0;

  state_t          r_state;
  logic [3:0]      r_bit_cnt;
  logic [7:0]      r_shreg;
  logic            r_parity;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_ext_pend;
  logic            r_brk_pend;
  logic            r_kclk_q;

  logic [7:0]      r_key_code;
  logic            r_key_release;
  logic            r_key_extended;
  logic            r_key_valid;
  logic            r_parity_err;
  logic            r_frame_err;

  logic            w_fall;
  logic            w_parity_ok;
  logic            w_timeout;

  assign w_fall      = r_kclk_q & ~bus.kclk;
  // odd parity over the eight data bits plus the parity bit
  assign w_parity_ok = ^{r_shreg, r_parity};
  assign w_timeout   = (r_to_cnt == C_TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_bit_cnt      <= 4'd0;
      r_shreg        <= 8'd0;
      r_parity       <= 1'b0;
      r_to_cnt       <= '0;
      r_ext_pend     <= 1'b0;
      r_brk_pend     <= 1'b0;
      r_kclk_q       <= 1'b1;
      r_key_code     <= 8'd0;
      r_key_release  <= 1'b0;
      r_key_extended <= 1'b0;
      r_key_valid    <= 1'b0;
      r_parity_err   <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_kclk_q     <= bus.kclk;
      r_key_valid  <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_fall && !bus.kdata) begin
            r_state   <= S_RECV;
            r_bit_cnt <= 4'd0;
            r_to_cnt  <= '0;
            r_shreg   <= 8'd0;
          end
        end

        S_RECV: begin
          if (w_fall) begin
            r_to_cnt  <= '0;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt < 4'd8) begin
              r_shreg[r_bit_cnt[2:0]] <= bus.kdata;
            end else if (r_bit_cnt == 4'd8) begin
              r_parity <= bus.kdata;
            end else begin
              // stop bit: classify the completed frame
              r_state   <= S_IDLE;
              r_bit_cnt <= 4'd0;
              if (!w_parity_ok) begin
                r_parity_err <= 1'b1;
                r_ext_pend   <= 1'b0;
                r_brk_pend   <= 1'b0;
              end else if (!bus.kdata) begin
                r_frame_err  <= 1'b1;
                r_ext_pend   <= 1'b0;
                r_brk_pend   <= 1'b0;
              end else if (r_shreg == C_EXT_CODE) begin
                r_ext_pend   <= 1'b1;
              end else if (r_shreg == C_BRK_CODE) begin
                r_brk_pend   <= 1'b1;
              end else begin
                r_key_valid    <= 1'b1;
                r_key_code     <= r_shreg;
                r_key_release  <= r_brk_pend;
                r_key_extended <= r_ext_pend;
                r_ext_pend     <= 1'b0;
                r_brk_pend     <= 1'b0;
              end
            end
          end else if (w_timeout) begin
            // keyboard stalled mid-frame: drop the partial byte
            r_frame_err <= 1'b1;
            r_state     <= S_IDLE;
            r_bit_cnt   <= 4'd0;
            r_to_cnt    <= '0;
            r_ext_pend  <= 1'b0;
            r_brk_pend  <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.key_code     = r_key_code;
  assign bus.key_release  = r_key_release;
  assign bus.key_extended = r_key_extended;
  assign bus.key_valid    = r_key_valid;
  assign bus.parity_err   = r_parity_err;
  assign bus.frame_err    = r_frame_err;
  assign bus.rx_busy      = (r_state == S_RECV);

endmodule
`default_nettype wire
